// File: rtl/OmpSsManager.sv
// Shared OmpSs manager constants: accelerator sizing and the schedule-data word layout.
package OmpSsManager;

    localparam int MAX_ACCS               = 16;
    localparam int ACC_BITS               = $clog2(MAX_ACCS);
    localparam int TASK_TYPE_BITS         = 34;
    localparam int SCHED_DATA_BITS        = 50;
    localparam int SCHED_DATA_COUNT_L     = 0;
    localparam int SCHED_DATA_ACCID_L     = 8;
    localparam int SCHED_DATA_TASK_TYPE_L = 16;
    localparam int SCHED_DATA_TASK_TYPE_H = 49;

endpackage

// File: rtl/sched_type_lookup_pkg.sv
// Types local to the task-type lookup block: FSM states and the decoded table entry.
package sched_type_lookup_pkg;

    import OmpSsManager::*;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CMP,
        RESPOND
    } state_t;

    typedef struct packed {
        logic [TASK_TYPE_BITS-1:0] task_type;
        logic [ACC_BITS-1:0]       acc_id;
        logic [ACC_BITS-1:0]       count;
    } sched_entry_t;

endpackage

// File: rtl/sched_type_lookup_if.sv
// Lookup request/response handshake between a requester (master) and the lookup block (slave).
interface sched_type_lookup_if;

    import OmpSsManager::*;

    logic                      req_valid;
    logic                      req_ready;
    logic [TASK_TYPE_BITS-1:0] req_task_type;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic                      rsp_found;
    logic [ACC_BITS-1:0]       rsp_acc_id;

    modport master (
        output req_valid, req_task_type, rsp_ready,
        input  req_ready, rsp_valid, rsp_found, rsp_acc_id
    );

    modport slave (
        input  req_valid, req_task_type, rsp_ready,
        output req_ready, rsp_valid, rsp_found, rsp_acc_id
    );

endinterface

// File: rtl/sched_rr_table.sv
// Per-entry round-robin offsets: one counter per table index, wrapping at the entry's instance count.
module sched_rr_table
    import OmpSsManager::ACC_BITS;
#(
    parameter int MAX_ACCS = OmpSsManager::MAX_ACCS
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ACC_BITS-1:0] rd_idx,
    input  logic                upd,
    input  logic [ACC_BITS-1:0] count_lim,
    output logic [ACC_BITS-1:0] rr_val
);

    logic [ACC_BITS-1:0] rr [MAX_ACCS];

    assign rr_val = rr[rd_idx];

    // NOTE: the table is flops, not RAM, so it can and must be cleared by reset
    // to restart every type's rotation at its base accelerator.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MAX_ACCS; i++) begin
                rr[i] <= '0;
            end
        end else if (upd) begin
            rr[rd_idx] <= (rr[rd_idx] == count_lim) ? '0 : rr[rd_idx] + ACC_BITS'(1);
        end
    end

endmodule

// File: rtl/sched_type_lookup.sv
// Linear search of the schedule-data table for a task type; returns the next accelerator
// for that type in round-robin order.
module sched_type_lookup
    import OmpSsManager::ACC_BITS;
    import OmpSsManager::TASK_TYPE_BITS;
    import OmpSsManager::SCHED_DATA_BITS;
    import OmpSsManager::SCHED_DATA_COUNT_L;
    import OmpSsManager::SCHED_DATA_ACCID_L;
    import OmpSsManager::SCHED_DATA_TASK_TYPE_L;
    import OmpSsManager::SCHED_DATA_TASK_TYPE_H;
    import sched_type_lookup_pkg::*;
#(
    parameter int MAX_ACCS = OmpSsManager::MAX_ACCS
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       types_valid,
    input  logic [ACC_BITS:0]          num_types,
    sched_type_lookup_if.slave         lk,
    output logic [ACC_BITS-1:0]        scheduleData_portB_addr,
    output logic                       scheduleData_portB_en,
    input  logic [SCHED_DATA_BITS-1:0] scheduleData_portB_dout
);

    state_t                    state, state_nx;
    logic [ACC_BITS-1:0]       index;
    logic [TASK_TYPE_BITS-1:0] type_q;
    logic [ACC_BITS:0]         ntypes_q;
    logic                      found_q;
    logic [ACC_BITS-1:0]       acc_id_q;
    logic [ACC_BITS-1:0]       count_q;
    logic [ACC_BITS-1:0]       rr_val;
    logic                      rr_upd;
    logic                      accept;
    logic                      match;
    logic                      last;
    sched_entry_t              entry;
    logic                      unused_dout;

    assign entry.task_type = scheduleData_portB_dout[SCHED_DATA_TASK_TYPE_H:SCHED_DATA_TASK_TYPE_L];
    assign entry.acc_id    = scheduleData_portB_dout[SCHED_DATA_ACCID_L +: ACC_BITS];
    assign entry.count     = scheduleData_portB_dout[SCHED_DATA_COUNT_L +: ACC_BITS];
    assign unused_dout     = ^scheduleData_portB_dout;

    assign accept = (state == IDLE) && types_valid && lk.req_valid;
    assign match  = (entry.task_type == type_q);
    assign last   = ({1'b0, index} == ntypes_q - (ACC_BITS + 1)'(1));

    assign scheduleData_portB_addr = index;
    assign lk.rsp_found            = found_q;
    assign lk.rsp_acc_id           = acc_id_q;

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned and infers a latch.
    always_comb begin
        state_nx              = state;
        lk.req_ready          = 1'b0;
        lk.rsp_valid          = 1'b0;
        scheduleData_portB_en = 1'b0;
        rr_upd                = 1'b0;
        unique case (state)
            IDLE: begin
                lk.req_ready = types_valid;
                if (accept) begin
                    state_nx = (num_types == '0) ? RESPOND : READ;
                end
            end
            READ: begin
                scheduleData_portB_en = 1'b1;
                state_nx              = CMP;
            end
            CMP: begin
                state_nx = (match || last) ? RESPOND : READ;
            end
            RESPOND: begin
                lk.rsp_valid = 1'b1;
                if (lk.rsp_ready) begin
                    state_nx = IDLE;
                    rr_upd   = found_q;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            index    <= '0;
            type_q   <= '0;
            ntypes_q <= '0;
            found_q  <= 1'b0;
            acc_id_q <= '0;
            count_q  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (accept) begin
                    type_q   <= lk.req_task_type;
                    ntypes_q <= num_types;
                    index    <= '0;
                    found_q  <= 1'b0;
                    acc_id_q <= '0;
                end
                CMP: begin
                    if (match) begin
                        found_q  <= 1'b1;
                        acc_id_q <= entry.acc_id + rr_val;
                        count_q  <= entry.count;
                    end else if (last) begin
                        found_q  <= 1'b0;
                        acc_id_q <= '0;
                    end else begin
                        index <= index + ACC_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Index is held through RESPOND, so the rr update lands on the matched entry.
    sched_rr_table #(
        .MAX_ACCS (MAX_ACCS)
    ) u_rr (
        .clk       (clk),
        .rstn      (rstn),
        .rd_idx    (index),
        .upd       (rr_upd),
        .count_lim (count_q),
        .rr_val    (rr_val)
    );

endmodule

// File: tb/tb_sched_type_lookup.sv
// Directed bench for sched_type_lookup: a driver queues expected responses, a monitor checks them.
module tb_sched_type_lookup;

    import OmpSsManager::*;

    typedef struct {
        logic       found;
        logic [3:0] acc;
        int         lat;
        string      name;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rstn;
    logic                       types_valid;
    logic [ACC_BITS:0]          num_types;
    logic [ACC_BITS-1:0]        addr;
    logic                       en;
    logic [SCHED_DATA_BITS-1:0] dout;
    logic [49:0]                mem [16];

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   first_cyc = 0;
    bit   rsp_seen = 1'b0;
    int   en_count = 0;
    int   en_before;

    sched_type_lookup_if lk ();

    sched_type_lookup #(.MAX_ACCS(16)) dut (
        .clk                     (clk),
        .rstn                    (rstn),
        .types_valid             (types_valid),
        .num_types               (num_types),
        .lk                      (lk.slave),
        .scheduleData_portB_addr (addr),
        .scheduleData_portB_en   (en),
        .scheduleData_portB_dout (dout)
    );

    always #5 clk = ~clk;

    // Table RAM model: one-cycle read latency.
    always @(posedge clk) if (en) dout <= mem[addr];

    always @(posedge clk) cyc++;

    function automatic logic [49:0] mk(input logic [33:0] t, input logic [3:0] a, input logic [3:0] c);
        return {t, 4'b0, a, 4'b0, c};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: latency is counted from the accepting edge (inclusive) to the edge raising rsp_valid.
    always @(negedge clk) begin
        if (!rstn) begin
            rsp_seen = 1'b0;
        end else begin
            if (en) en_count++;
            if (lk.req_valid && lk.req_ready) acc_cyc = cyc + 1;
            if (lk.rsp_valid && !rsp_seen) begin
                rsp_seen  = 1'b1;
                first_cyc = cyc;
            end
            if (lk.rsp_valid && lk.rsp_ready) begin
                rsp_seen = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", {63'b0, lk.rsp_valid}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_found"}, {63'b0, lk.rsp_found}, {63'b0, e.found});
                    check({e.name, "_acc_id"}, {60'b0, lk.rsp_acc_id}, {60'b0, e.acc});
                    check({e.name, "_latency"}, 64'(first_cyc - acc_cyc + 1), 64'(e.lat));
                end
            end
        end
    end

    task automatic issue(input logic [33:0] t, input bit expect_rsp, input logic f,
                         input logic [3:0] a, input int lat, input string nm);
        int  guard = 0;
        bit  got   = 1'b0;
        if (expect_rsp) sb.push_back('{found: f, acc: a, lat: lat, name: nm});
        lk.req_task_type = t;
        lk.req_valid     = 1'b1;
        while (!got && guard < 50) begin
            @(negedge clk);
            got = lk.req_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        lk.req_valid = 1'b0;
        check({nm, "_accepted"}, {63'b0, got}, 64'd1);
    endtask

    task automatic wait_rsp(input string nm);
        int g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        check({nm, "_rsp_pending"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rstn             = 1'b0;
        types_valid      = 1'b0;
        num_types        = '0;
        lk.req_valid     = 1'b0;
        lk.req_task_type = '0;
        lk.rsp_ready     = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = mk(34'd0, 4'd0, 4'd0);
        mem[0] = mk(34'd11, 4'd0, 4'd1);
        mem[1] = mk(34'd22, 4'd2, 4'd0);
        mem[2] = mk(34'd44, 4'd4, 4'd2);

        #1;
        check("rst_rsp_valid", {63'b0, lk.rsp_valid}, 64'd0);
        check("rst_req_ready", {63'b0, lk.req_ready}, 64'd0);
        check("rst_en", {63'b0, en}, 64'd0);
        check("rst_addr", {60'b0, addr}, 64'd0);
        check("rst_found", {63'b0, lk.rsp_found}, 64'd0);
        check("rst_acc_id", {60'b0, lk.rsp_acc_id}, 64'd0);

        repeat (3) @(posedge clk);
        #1;
        rstn        = 1'b1;
        types_valid = 1'b1;
        num_types   = 5'd2;
        #1;
        check("idle_req_ready", {63'b0, lk.req_ready}, 64'd1);

        // Type 11 rotates over two instances starting at base 0.
        for (int i = 0; i < 4; i++) begin
            issue(34'd11, 1'b1, 1'b1, 4'(i % 2), 3, "rr11");
            wait_rsp("rr11");
        end

        // Type 22 at index 1, single instance.
        repeat (2) begin
            issue(34'd22, 1'b1, 1'b1, 4'd2, 5, "t22");
            wait_rsp("t22");
        end

        // Miss leaves rr untouched: next 11 still gets base 0.
        issue(34'd33, 1'b1, 1'b0, 4'd0, 5, "miss33");
        wait_rsp("miss33");
        issue(34'd11, 1'b1, 1'b1, 4'd0, 3, "post_miss11");
        wait_rsp("post_miss11");

        // Backpressure: response held 10 cycles, new requests ignored.
        num_types    = 5'd3;
        lk.rsp_ready = 1'b0;
        issue(34'd44, 1'b1, 1'b1, 4'd4, 7, "hold44");
        for (int g = 0; g < 20 && !lk.rsp_valid; g++) begin
            @(posedge clk);
            #1;
        end
        lk.req_task_type = 34'd11;
        lk.req_valid     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {63'b0, lk.rsp_valid}, 64'd1);
            check("hold_found", {63'b0, lk.rsp_found}, 64'd1);
            check("hold_acc_id", {60'b0, lk.rsp_acc_id}, 64'd4);
            check("hold_req_ready", {63'b0, lk.req_ready}, 64'd0);
        end
        lk.req_valid = 1'b0;
        lk.rsp_ready = 1'b1;
        wait_rsp("hold44");
        issue(34'd44, 1'b1, 1'b1, 4'd5, 7, "after_hold44");
        wait_rsp("after_hold44");

        // Empty table: immediate miss, no table reads.
        num_types = 5'd0;
        en_before = en_count;
        issue(34'd11, 1'b1, 1'b0, 4'd0, 1, "empty");
        wait_rsp("empty");
        check("empty_no_read", 64'(en_count - en_before), 64'd0);

        // types_valid dropping mid-search completes the search but blocks the next accept.
        num_types = 5'd2;
        issue(34'd22, 1'b1, 1'b1, 4'd2, 5, "tv_drop");
        types_valid = 1'b0;
        wait_rsp("tv_drop");
        check("tv_drop_req_ready", {63'b0, lk.req_ready}, 64'd0);
        types_valid = 1'b1;

        // Reset during CMP: rr[0] is 1 here; reset must drop the lookup and clear rr.
        issue(34'd11, 1'b0, 1'b0, 4'd0, 0, "rst_mid");
        check("rst_mid_read_en", {63'b0, en}, 64'd1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("rst_mid_rsp_valid", {63'b0, lk.rsp_valid}, 64'd0);
        check("rst_mid_en", {63'b0, en}, 64'd0);
        check("rst_mid_addr", {60'b0, addr}, 64'd0);
        check("rst_mid_found", {63'b0, lk.rsp_found}, 64'd0);
        check("rst_mid_acc_id", {60'b0, lk.rsp_acc_id}, 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_no_rsp", {63'b0, lk.rsp_valid}, 64'd0);
        issue(34'd11, 1'b1, 1'b1, 4'd0, 3, "post_rst11");
        wait_rsp("post_rst11");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sched_type_lookup.md
SCHED_TYPE_LOOKUP -- requirements
Module: sched_type_lookup

Interface
REQ-001 SHALL have parameter MAX_ACCS, default from OmpSsManager package (16), max accelerators and max task-type entries.
REQ-002 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have types_valid  input  1  schedule-data table fully written by the bitinfo parser.
REQ-005 SHALL have num_types  input  ACC_BITS+1  number of valid table entries, sampled at request acceptance.
REQ-006 SHALL have req_valid / req_ready  input / output  1 each  lookup request handshake.
REQ-007 SHALL have req_task_type  input  34  task type to look up.
REQ-008 SHALL have rsp_valid / rsp_ready  output / input  1 each  response handshake.
REQ-009 SHALL have rsp_found  output  1  entry matched.
REQ-010 SHALL have rsp_acc_id  output  ACC_BITS  selected accelerator ID.
REQ-011 SHALL have scheduleData_portB_addr  output  ACC_BITS  table read address.
REQ-012 SHALL have scheduleData_portB_en  output  1  table read enable.
REQ-013 SHALL have scheduleData_portB_dout  input  50  table word, valid one cycle after en.

Function
REQ-014 SHALL implement states IDLE, READ, CMP, RESPOND.
REQ-015 SHALL drive req_ready=1 only in IDLE with types_valid=1; accept on req_valid&req_ready; latch task type and num_types.
REQ-016 On accept with num_types=0 SHALL go to RESPOND with found=0; otherwise to READ with index=0.
REQ-017 READ SHALL drive portB_en=1 and addr=index; en=0 in all other states; next state CMP.
REQ-018 CMP SHALL compare dout[SCHED_DATA_TASK_TYPE_H:L] with the latched type.
REQ-019 On match: rsp_found=1; rsp_acc_id=ACCID field + rr[index], truncated to ACC_BITS; go to RESPOND.
REQ-020 On miss with index=num_types-1: found=0, acc_id=0, go to RESPOND; otherwise index+1, go to READ.
REQ-021 First match wins; later duplicates are never read.
REQ-022 Latency: match at index k gives rsp_valid 2k+3 cycles after the accept edge; miss gives 2N+1; N=0 gives 1.
REQ-023 RESPOND SHALL hold rsp_valid=1 with stable rsp_found/rsp_acc_id until rsp_ready=1, then go to IDLE.
REQ-024 rr table: MAX_ACCS registers, ACC_BITS wide, one per entry index.
REQ-025 On response handshake with found=1, rr[index] SHALL become 0 if it equals the COUNT field (instances-1), else rr[index]+1; rr is otherwise unchanged.
REQ-026 types_valid falling mid-search SHALL NOT abort the search; it only blocks the next accept.
REQ-027 req_valid during READ/CMP/RESPOND SHALL be ignored (req_ready=0).

Reset
REQ-028 rstn=0 SHALL asynchronously force IDLE, clear index and rr table, and set rsp_valid, rsp_found, rsp_acc_id, portB_en and portB_addr to 0.
REQ-029 Reset mid-search or mid-response SHALL drop the transaction with no response after release.

Structure
REQ-030 MAX_ACCS, ACC_BITS and SCHED_DATA_ACCID_L/COUNT_L/TASK_TYPE_L/TASK_TYPE_H SHALL come from OmpSsManager; no local copies.
REQ-031 The rr table plus wrap logic SHALL be one sub-module, sched_rr_table: read index, update strobe, count limit.

Verification
REQ-032 Table {type 11: base 0, count 1; type 22: base 2, count 0}, N=2; four requests for 11 with rsp_ready=1 -> acc_id 0,1,0,1, found=1, latency 3.
REQ-033 Same table, request 22 -> found=1, acc_id 2, rsp_valid 5 cycles after accept; repeated -> always 2.
REQ-034 Request 33 -> found=0, acc_id 0, latency 5; no rr entry changes.
REQ-035 num_types=0, any request -> found=0 after 1 cycle, portB_en never asserted.
REQ-036 rsp_ready held 0 for 10 cycles -> outputs stable, req_ready=0; then rsp_ready=1 -> one rr update.
REQ-037 rstn pulsed low during CMP -> outputs 0 immediately, no response, next 11 lookup returns acc_id 0.
